// File: rtl/sisc_pkg.sv
// +----------------------------------------------------------------------+
// | Module   : sisc_pkg                                                  |
// | Desc     : Shared SISC encodings for the memory arbiter.             |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

package sisc_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

  // On a tie, round-robin hands the grant to whoever was not served last.
  function automatic arb_owner_t arb_pick(input logic       i_req,
                                          input logic       d_req,
                                          input arb_owner_t last,
                                          input logic       rr);
    if (i_req && d_req) begin
      return (rr && (last == OWN_D)) ? OWN_I : OWN_D;
    end
    return d_req ? OWN_D : OWN_I;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arb_if.sv
// +----------------------------------------------------------------------+
// | Module   : mem_arb_if                                                |
// | Desc     : Requester and memory-port bundle for mem_arb.             |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

interface mem_arb_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_done;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_done;
  logic [DW-1:0] rdata;
  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output i_done, d_done, rdata, m_en, m_we, m_addr, m_wdata, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  i_done, d_done, rdata, m_en, m_we, m_addr, m_wdata, busy
  );
endinterface

`default_nettype wire

// File: rtl/mem_arb.sv
// +----------------------------------------------------------------------+
// | Module   : mem_arb                                                   |
// | Desc     : Single-port memory arbiter, fetch vs. load/store path.    |
// |            Define MEM_ARB_RR_EN for round-robin tie-breaking.        |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_arb
  import sisc_pkg::*;
#(
  parameter int AW  = 16,
  parameter int DW  = 32,
  parameter int LAT = 1
) (
  input  wire logic   clk,
  input  wire logic   rst_f,
  mem_arb_if.slave    bus
);

  localparam logic [1:0] c_WAIT_LOAD = (LAT > 1) ? 2'(LAT - 2) : 2'd0;

  if (LAT < 1 || LAT > 4) begin : g_lat_check
    $error("mem_arb: LAT must be in 1..4");
  end

  arb_state_t r_state;
  arb_owner_t r_owner;
  logic [1:0] r_cnt;
  arb_owner_t w_pick;

`ifdef MEM_ARB_RR_EN
  arb_owner_t r_last_owner;
  assign w_pick = arb_pick(bus.i_req, bus.d_req, r_last_owner, 1'b1);
`else
  assign w_pick = arb_pick(bus.i_req, bus.d_req, OWN_I, 1'b0);
`endif

  always_ff @(posedge clk) begin
    if (rst_f) begin
      r_state     <= ARB_IDLE;
      r_owner     <= OWN_I;
      r_cnt       <= 2'd0;
      bus.i_done  <= 1'b0;
      bus.d_done  <= 1'b0;
      bus.rdata   <= '0;
      bus.m_en    <= 1'b0;
      bus.m_we    <= 1'b0;
      bus.m_addr  <= '0;
      bus.m_wdata <= '0;
      bus.busy    <= 1'b0;
`ifdef MEM_ARB_RR_EN
      r_last_owner <= OWN_I;
`endif
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (bus.i_req || bus.d_req) begin
            // The m_* registers double as the transaction latch.
            r_owner  <= w_pick;
            r_state  <= ARB_ISSUE;
            bus.m_en <= 1'b1;
            bus.busy <= 1'b1;
            if (w_pick == OWN_D) begin
              bus.m_we    <= bus.d_we;
              bus.m_addr  <= bus.d_addr;
              bus.m_wdata <= bus.d_wdata;
            end else begin
              bus.m_we    <= 1'b0;
              bus.m_addr  <= bus.i_addr;
              bus.m_wdata <= '0;
            end
          end
        end
        ARB_ISSUE: begin
          bus.m_en <= 1'b0;
          bus.m_we <= 1'b0;
          if (LAT > 1) begin
            r_cnt   <= c_WAIT_LOAD;
            r_state <= ARB_WAIT;
          end else begin
            r_state    <= ARB_DONE;
            bus.i_done <= (r_owner == OWN_I);
            bus.d_done <= (r_owner == OWN_D);
          end
        end
        ARB_WAIT: begin
          if (r_cnt == 2'd0) begin
            r_state    <= ARB_DONE;
            bus.i_done <= (r_owner == OWN_I);
            bus.d_done <= (r_owner == OWN_D);
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        ARB_DONE: begin
          bus.rdata  <= bus.m_rdata;
          bus.i_done <= 1'b0;
          bus.d_done <= 1'b0;
          bus.busy   <= 1'b0;
          r_state    <= ARB_IDLE;
`ifdef MEM_ARB_RR_EN
          r_last_owner <= r_owner;
`endif
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arb.sv
// +----------------------------------------------------------------------+
// | Module   : tb_mem_arb                                                |
// | Desc     : Self-checking bench for mem_arb at LAT=1 and LAT=3.       |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mem_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic [1:0]  rst_f, i_req, d_req, d_we;
  logic [15:0] i_addr [2];
  logic [15:0] d_addr [2];
  logic [31:0] d_wdata [2];
  logic        i_done_o [2];
  logic        d_done_o [2];
  logic        m_en_o [2];
  logic        m_we_o [2];
  logic        busy_o [2];
  logic [15:0] m_addr_o [2];
  logic [31:0] m_wdata_o [2];
  logic [31:0] rdata_o [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 1 : 3;

    mem_arb_if #(.AW(16), .DW(32)) bus ();

    mem_arb #(.AW(16), .DW(32), .LAT(LAT)) dut (
      .clk   (clk),
      .rst_f (rst_f[g]),
      .bus   (bus)
    );

    assign bus.i_req   = i_req[g];
    assign bus.i_addr  = i_addr[g];
    assign bus.d_req   = d_req[g];
    assign bus.d_we    = d_we[g];
    assign bus.d_addr  = d_addr[g];
    assign bus.d_wdata = d_wdata[g];
    assign i_done_o[g]  = bus.i_done;
    assign d_done_o[g]  = bus.d_done;
    assign m_en_o[g]    = bus.m_en;
    assign m_we_o[g]    = bus.m_we;
    assign busy_o[g]    = bus.busy;
    assign m_addr_o[g]  = bus.m_addr;
    assign m_wdata_o[g] = bus.m_wdata;
    assign rdata_o[g]   = bus.rdata;

    // Synchronous memory: read data is present exactly LAT cycles after m_en.
    logic [31:0] mem [256];
    logic [31:0] shadow [256];
    logic [31:0] pipe [LAT];

    initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h5A000000 | i;
      mem[8'h04] = 32'h1234ABCD;
      mem[8'h20] = 32'hCAFEF00D;
      for (int i = 0; i < 256; i++) shadow[i] = mem[i];
    end

    always @(posedge clk) begin
      if (bus.m_en && bus.m_we) mem[bus.m_addr[7:0]] <= bus.m_wdata;
      pipe[0] <= (bus.m_en && !bus.m_we) ? mem[bus.m_addr[7:0]] : 32'h0;
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign bus.m_rdata = pipe[LAT-1];

    // Reference model: t counts cycles since the grant (0 = no transaction).
    int          t = 0;
    bit          armed = 1'b0;
    bit          od, owe, rk, last_d;
    logic [15:0] ema;
    logic [31:0] owd, nxt, exp_rd;

    always @(posedge clk) begin
      if (rst_f[g]) begin
        t = 0; ema = 16'h0; exp_rd = 32'h0; rk = 1'b1; armed = 1'b1; last_d = 1'b0;
      end else if (t == LAT + 1) begin
        t = 0;
        if (owe) rk = 1'b0;
        else begin exp_rd = nxt; rk = 1'b1; end
        last_d = od;
      end else if (t > 0) begin
        t = t + 1;
      end else if (i_req[g] || d_req[g]) begin
        od  = d_req[g] && !(i_req[g] && RR && last_d);
        ema = od ? d_addr[g] : i_addr[g];
        owe = od && d_we[g];
        owd = d_wdata[g];
        t   = 1;
        if (owe) shadow[ema[7:0]] = owd;
        else     nxt = shadow[ema[7:0]];
      end
    end

    always @(negedge clk) begin
      if (armed) begin
        chk1($sformatf("busy[%0d]", g),   bus.busy,   t > 0);
        chk1($sformatf("m_en[%0d]", g),   bus.m_en,   t == 1);
        chk1($sformatf("i_done[%0d]", g), bus.i_done, (t == LAT + 1) && !od);
        chk1($sformatf("d_done[%0d]", g), bus.d_done, (t == LAT + 1) && od);
        chk($sformatf("m_addr[%0d]", g),  {16'h0, bus.m_addr}, {16'h0, ema});
        if (t == 1) chk1($sformatf("m_we[%0d]", g), bus.m_we, owe);
        if (t == 1 && owe) chk($sformatf("m_wdata[%0d]", g), bus.m_wdata, owd);
        if (rk) chk($sformatf("rdata[%0d]", g), bus.rdata, exp_rd);
      end
    end
  end

  // One transaction (or a tie) driven until every raised request has seen its done.
  task automatic run(input int g, input bit ri, input bit rd, input bit we,
                     input logic [15:0] ia, input logic [15:0] da, input logic [31:0] wd,
                     input int chg, input logic [15:0] chg_addr,
                     output int ce, output int cid, output int cdd, output int nb,
                     output logic [15:0] ea, output logic [31:0] ewd, output logic ewe);
    int c0;
    bit pi, pd, dn_i, dn_d;
    @(posedge clk); #1;
    i_req[g] = ri; i_addr[g] = ia;
    d_req[g] = rd; d_we[g] = we; d_addr[g] = da; d_wdata[g] = wd;
    c0 = cyc;
    ce = -1; cid = -1; cdd = -1; nb = 0; ea = 16'h0; ewd = 32'h0; ewe = 1'b0;
    pi = ri; pd = rd;
    for (int k = 0; k < 24 && (pi || pd); k++) begin
      @(negedge clk);
      if (m_en_o[g] && ce < 0) begin
        ce = cyc - c0; ea = m_addr_o[g]; ewd = m_wdata_o[g]; ewe = m_we_o[g];
      end
      if (busy_o[g]) nb++;
      dn_i = i_done_o[g];
      dn_d = d_done_o[g];
      if (dn_i && cid < 0) cid = cyc - c0;
      if (dn_d && cdd < 0) cdd = cyc - c0;
      @(posedge clk); #1;
      if (dn_i) begin i_req[g] = 1'b0; pi = 1'b0; end
      if (dn_d) begin d_req[g] = 1'b0; pd = 1'b0; end
      if (chg > 0 && (cyc - c0) == chg) begin
        d_addr[g] = chg_addr; d_wdata[g] = 32'h0BAD0BAD;
      end
    end
    if (pi || pd) begin
      n_vec++; n_err++;
      $display("FAIL run_timeout[%0d]: got pending i=%0b d=%0b expected none", g, pi, pd);
      i_req[g] = 1'b0; d_req[g] = 1'b0;
    end
  endtask

  initial begin
    int ce, cid, cdd, nb, nd;
    logic [15:0] ea;
    logic [31:0] ewd;
    logic        ewe;

    rst_f = 2'b11; i_req = 2'b00; d_req = 2'b00; d_we = 2'b00;
    for (int i = 0; i < 2; i++) begin
      i_addr[i] = 16'h0; d_addr[i] = 16'h0; d_wdata[i] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1 rst_f = 2'b00;

    @(negedge clk);
    chk1("rst_busy", busy_o[0], 1'b0);
    chk1("rst_m_en", m_en_o[0], 1'b0);
    chk1("rst_i_done", i_done_o[0], 1'b0);
    chk("rst_rdata", rdata_o[0], 32'h0);
    chk("rst_m_addr", {16'h0, m_addr_o[1]}, 32'h0);

    // Fetch at LAT=1
    run(0, 1, 0, 0, 16'h0004, 16'h0, 32'h0, 0, 16'h0, ce, cid, cdd, nb, ea, ewd, ewe);
    chk("s1_en_cycle", ce, 1);
    chk("s1_done_cycle", cid, 2);
    chk("s1_m_addr", {16'h0, ea}, 32'h0004);
    chk("s1_rdata", rdata_o[0], 32'h1234ABCD);

    // Store
    run(0, 0, 1, 1, 16'h0, 16'h0010, 32'hDEADBEEF, 0, 16'h0, ce, cid, cdd, nb, ea, ewd, ewe);
    chk1("s2_m_we", ewe, 1'b1);
    chk("s2_m_addr", {16'h0, ea}, 32'h0010);
    chk("s2_m_wdata", ewd, 32'hDEADBEEF);
    chk("s2_d_done_cycle", cdd, 2);
    chk("s2_no_i_done", cid, -1);

    run(0, 1, 0, 0, 16'h0010, 16'h0, 32'h0, 0, 16'h0, ce, cid, cdd, nb, ea, ewd, ewe);
    chk("s2_readback", rdata_o[0], 32'hDEADBEEF);

    // Simultaneous requests: data first, fetch after the one-cycle IDLE gap
    run(0, 1, 1, 0, 16'h0004, 16'h0010, 32'h0, 0, 16'h0, ce, cid, cdd, nb, ea, ewd, ewe);
    chk("tie_d_done_cycle", cdd, 2);
    chk("tie_i_done_cycle", cid, 5);
    chk("tie_rdata", rdata_o[0], 32'h1234ABCD);

`ifdef MEM_ARB_RR_EN
    run(0, 0, 1, 0, 16'h0, 16'h0010, 32'h0, 0, 16'h0, ce, cid, cdd, nb, ea, ewd, ewe);
    run(0, 1, 1, 0, 16'h0004, 16'h0010, 32'h0, 0, 16'h0, ce, cid, cdd, nb, ea, ewd, ewe);
    chk("rr_i_done_cycle", cid, 2);
    chk("rr_d_done_cycle", cdd, 5);
    chk("rr_rdata", rdata_o[0], 32'hDEADBEEF);
`endif

    // LAT=3 fetch
    run(1, 1, 0, 0, 16'h0020, 16'h0, 32'h0, 0, 16'h0, ce, cid, cdd, nb, ea, ewd, ewe);
    chk("lat3_en_cycle", ce, 1);
    chk("lat3_done_after_issue", cid - ce, 3);
    chk("lat3_busy_cycles", nb, 4);
    chk("lat3_rdata", rdata_o[1], 32'hCAFEF00D);

    // Reset while in WAIT
    @(posedge clk); #1;
    i_req[1] = 1'b1; i_addr[1] = 16'h0020;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk1("rstw_busy_in_wait", busy_o[1], 1'b1);
    rst_f[1] = 1'b1; i_req[1] = 1'b0;
    @(posedge clk); #1;
    rst_f[1] = 1'b0;
    chk1("rstw_busy", busy_o[1], 1'b0);
    chk1("rstw_m_en", m_en_o[1], 1'b0);
    chk("rstw_rdata", rdata_o[1], 32'h0);
    chk("rstw_m_addr", {16'h0, m_addr_o[1]}, 32'h0);
    nd = 0;
    repeat (5) begin
      @(negedge clk);
      nd += int'(i_done_o[1] | d_done_o[1]);
    end
    chk("rstw_no_done", nd, 0);
    run(1, 1, 0, 0, 16'h0004, 16'h0, 32'h0, 0, 16'h0, ce, cid, cdd, nb, ea, ewd, ewe);
    chk("rstw_after_en_cycle", ce, 1);
    chk("rstw_after_done_cycle", cid, 4);
    chk("rstw_after_rdata", rdata_o[1], 32'h1234ABCD);

    // Address/data change during WAIT must not affect the granted store
    run(1, 0, 1, 1, 16'h0, 16'h0010, 32'h11112222, 2, 16'h0030, ce, cid, cdd, nb, ea, ewd, ewe);
    chk("chg_d_done_cycle", cdd, 4);
    run(1, 1, 0, 0, 16'h0010, 16'h0, 32'h0, 0, 16'h0, ce, cid, cdd, nb, ea, ewd, ewe);
    chk("chg_rd_0010", rdata_o[1], 32'h11112222);
    run(1, 1, 0, 0, 16'h0030, 16'h0, 32'h0, 0, 16'h0, ce, cid, cdd, nb, ea, ewd, ewe);
    chk("chg_rd_0030", rdata_o[1], 32'h5A000030);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish before 1ms");
    $fatal(1);
  end

endmodule

`default_nettype wire
